// File: rtl/vx_uop_retire_tracker_pkg.sv
// Shared definitions for the uop retire tracker and the uop sequencer that feeds it.
package vx_uop_retire_tracker_pkg;

  localparam int NUM_WARPS_DEF  = 4;
  localparam int UUID_WIDTH_DEF = 44;
  localparam int MAX_UOPS_DEF   = 8;

  // Width of a uop count able to hold 0..MAX_UOPS_DEF; the sequencer sizes alloc_count with this.
  localparam int UOP_CNT_BITS = $clog2(MAX_UOPS_DEF + 1);

  // Per-warp retire tracking state.
  typedef enum logic [1:0] {
    UOP_TRK_IDLE   = 2'd0,
    UOP_TRK_ACTIVE = 2'd1,
    UOP_TRK_DONE   = 2'd2
  } uop_trk_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_uop_retire_tracker_rr_arb.sv
// Round-robin arbiter: the search starts just after the last granted index,
// so the most recently served requester has the lowest priority.
module vx_uop_retire_tracker_rr_arb
  import vx_uop_retire_tracker_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = clog2_min1(NUM_REQS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_REQS-1:0] requests_i,
  input  logic                grant_ready_i,
  output logic                grant_valid_o,
  output logic [IDX_W-1:0]    grant_index_o
);

  logic [IDX_W-1:0] last_q;

  // Pick the first requester after last_q, wrapping around; last_q itself is checked last.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    for (int i = 1; i <= NUM_REQS; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NUM_REQS;
      if (!grant_valid_o && requests_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_index_o = IDX_W'(idx);
      end
    end
  end

  // Remember the winner only when its grant is actually consumed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= '0;
    end else if (grant_valid_o && grant_ready_i) begin
      last_q <= grant_index_o;
    end
  end

endmodule

// File: rtl/vx_uop_retire_tracker.sv
// Retire-side tracker for microcoded macro instructions: one entry per warp counts
// committed uops and emits a single macro commit once the whole sequence has retired.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
// valid never waits on ready; once macro_commit_valid_o is 1 its payload holds
// stable until macro_commit_ready_i is seen high. alloc_ready_o depends only on
// the addressed entry's state, never on alloc_valid_i.
module vx_uop_retire_tracker
  import vx_uop_retire_tracker_pkg::*;
#(
  parameter  int NUM_WARPS = NUM_WARPS_DEF,
  parameter  int MAX_UOPS  = MAX_UOPS_DEF,
  parameter  int UUID_W    = UUID_WIDTH_DEF,
  localparam int NW_BITS   = clog2_min1(NUM_WARPS),
  localparam int CNT_BITS  = $clog2(MAX_UOPS + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [NW_BITS-1:0]     alloc_wid_i,
  input  logic [UUID_W-1:0]      alloc_uuid_i,
  input  logic [CNT_BITS-1:0]    alloc_count_i,
  input  logic                   uop_commit_valid_i,
  output logic                   uop_commit_ready_o,
  input  logic [NW_BITS-1:0]     uop_commit_wid_i,
  input  logic [UUID_W-1:0]      uop_commit_uuid_i,
  output logic                   macro_commit_valid_o,
  input  logic                   macro_commit_ready_i,
  output logic [NW_BITS-1:0]     macro_commit_wid_o,
  output logic [UUID_W-1:0]      macro_commit_uuid_o,
  output logic [NUM_WARPS-1:0]   busy_mask_o,
  output logic                   err_orphan_o,
  output logic [2*NUM_WARPS-1:0] dbg_state_o
);

  uop_trk_state_e      state_q [NUM_WARPS];
  logic [CNT_BITS-1:0] rem_q   [NUM_WARPS];
  logic [UUID_W-1:0]   uuid_q  [NUM_WARPS];

  logic                mc_valid_q;
  logic [NW_BITS-1:0]  mc_wid_q;
  logic [UUID_W-1:0]   mc_uuid_q;
  logic                err_q;
  logic                commit_rdy_q;

  logic                alloc_fire;
  logic                commit_fire;
  logic                commit_match;
  logic                out_free;
  logic                out_load;
  logic [NUM_WARPS-1:0] done_req;
  logic                grant_valid;
  logic [NW_BITS-1:0]  grant_idx;

  assign alloc_ready_o = (state_q[alloc_wid_i] == UOP_TRK_IDLE);
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign commit_fire   = uop_commit_valid_i && commit_rdy_q;
  // A commit only counts against an ACTIVE entry carrying the same tag.
  assign commit_match  = commit_fire
                      && (state_q[uop_commit_wid_i] == UOP_TRK_ACTIVE)
                      && (uuid_q[uop_commit_wid_i] == uop_commit_uuid_i);
  // The output register can take a new entry when empty or draining this cycle.
  assign out_free      = !mc_valid_q || macro_commit_ready_i;
  assign out_load      = out_free && grant_valid;

  // Per-warp status views derived from entry state.
  always_comb begin
    done_req    = '0;
    busy_mask_o = '0;
    dbg_state_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      done_req[w]         = (state_q[w] == UOP_TRK_DONE);
      busy_mask_o[w]      = (state_q[w] != UOP_TRK_IDLE);
      dbg_state_o[2*w +: 2] = state_q[w];
    end
  end

  vx_uop_retire_tracker_rr_arb #(
    .NUM_REQS (NUM_WARPS)
  ) u_done_arb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .requests_i    (done_req),
    .grant_ready_i (out_free),
    .grant_valid_o (grant_valid),
    .grant_index_o (grant_idx)
  );

  // Entry FSMs: alloc, matching commits and retirement touch disjoint states,
  // so at most one of the three updates can target a given warp in a cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= UOP_TRK_IDLE;
        rem_q[w]   <= '0;
        uuid_q[w]  <= '0;
      end
    end else begin
      if (commit_match) begin
        rem_q[uop_commit_wid_i] <= rem_q[uop_commit_wid_i] - CNT_BITS'(1);
        if (rem_q[uop_commit_wid_i] == CNT_BITS'(1)) begin
          state_q[uop_commit_wid_i] <= UOP_TRK_DONE;
        end
      end
      if (alloc_fire) begin
        rem_q[alloc_wid_i]   <= alloc_count_i;
        uuid_q[alloc_wid_i]  <= alloc_uuid_i;
        // A zero-length sequence has nothing to wait for and retires directly.
        state_q[alloc_wid_i] <= (alloc_count_i == '0) ? UOP_TRK_DONE : UOP_TRK_ACTIVE;
      end
      if (out_load) begin
        state_q[grant_idx] <= UOP_TRK_IDLE;
      end
    end
  end

  // Single-entry macro commit output register with sticky orphan flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mc_valid_q   <= 1'b0;
      mc_wid_q     <= '0;
      mc_uuid_q    <= '0;
      err_q        <= 1'b0;
      commit_rdy_q <= 1'b0;
    end else begin
      commit_rdy_q <= 1'b1;
      if (commit_fire && !commit_match) begin
        err_q <= 1'b1;
      end
      if (out_load) begin
        mc_valid_q <= 1'b1;
        mc_wid_q   <= grant_idx;
        mc_uuid_q  <= uuid_q[grant_idx];
      end else if (out_free) begin
        mc_valid_q <= 1'b0;
      end
    end
  end

  assign macro_commit_valid_o = mc_valid_q;
  assign macro_commit_wid_o   = mc_wid_q;
  assign macro_commit_uuid_o  = mc_uuid_q;
  assign err_orphan_o         = err_q;
  assign uop_commit_ready_o   = commit_rdy_q;

endmodule

// File: tb/tb_vx_uop_retire_tracker.sv
// Bench for vx_uop_retire_tracker: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the retire rules.
module tb_vx_uop_retire_tracker;
  import vx_uop_retire_tracker_pkg::*;

  localparam int NW  = 4;
  localparam int NWB = 2;
  localparam int CB  = 4;
  localparam int UW  = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_valid, a_ready;
  logic [NWB-1:0] a_wid;
  logic [UW-1:0] a_uuid;
  logic [CB-1:0] a_cnt;
  logic          uc_valid, uc_ready;
  logic [NWB-1:0] uc_wid;
  logic [UW-1:0] uc_uuid;
  logic          mc_valid, mc_ready;
  logic [NWB-1:0] mc_wid;
  logic [UW-1:0] mc_uuid;
  logic [NW-1:0] busy;
  logic          err;
  logic [2*NW-1:0] dbg_state;

  vx_uop_retire_tracker dut (
    .clk_i                (clk),
    .reset_i              (rst),
    .alloc_valid_i        (a_valid),
    .alloc_ready_o        (a_ready),
    .alloc_wid_i          (a_wid),
    .alloc_uuid_i         (a_uuid),
    .alloc_count_i        (a_cnt),
    .uop_commit_valid_i   (uc_valid),
    .uop_commit_ready_o   (uc_ready),
    .uop_commit_wid_i     (uc_wid),
    .uop_commit_uuid_i    (uc_uuid),
    .macro_commit_valid_o (mc_valid),
    .macro_commit_ready_i (mc_ready),
    .macro_commit_wid_o   (mc_wid),
    .macro_commit_uuid_o  (mc_uuid),
    .busy_mask_o          (busy),
    .err_orphan_o         (err),
    .dbg_state_o          (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [UW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per warp: 0 = free, 1 = waiting for uops, 2 = finished and waiting to retire.
  int            m_st   [NW];
  int            m_rem  [NW];
  logic [UW-1:0] m_uuid [NW];
  bit            m_ov;
  int            m_owid;
  logic [UW-1:0] m_ouuid;
  int            m_last;
  bit            m_err;
  bit            m_crdy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NW; w++) begin
        m_st[w] = 0; m_rem[w] = 0; m_uuid[w] = '0;
      end
      m_ov = 0; m_owid = 0; m_ouuid = '0; m_last = 0; m_err = 0; m_crdy = 0;
    end else begin
      bit free;
      int g;
      int cw;
      int aw;
      free = !m_ov || mc_ready;
      g = -1;
      for (int k = 1; k <= NW; k++) begin
        int w;
        w = (m_last + k) % NW;
        if (g < 0 && m_st[w] == 2) g = w;
      end
      if (uc_valid && m_crdy) begin
        cw = int'(uc_wid);
        if (m_st[cw] == 1 && m_uuid[cw] == uc_uuid) begin
          m_rem[cw] = m_rem[cw] - 1;
          if (m_rem[cw] == 0) m_st[cw] = 2;
        end else begin
          m_err = 1;
        end
      end
      aw = int'(a_wid);
      if (a_valid && m_st[aw] == 0) begin
        m_uuid[aw] = a_uuid;
        m_rem[aw]  = int'(a_cnt);
        m_st[aw]   = (a_cnt == 0) ? 2 : 1;
      end
      if (free) begin
        if (g >= 0) begin
          m_ov = 1; m_owid = g; m_ouuid = m_uuid[g]; m_st[g] = 0; m_last = g;
        end else begin
          m_ov = 0;
        end
      end
      m_crdy = 1;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [NW-1:0] eb;
      chk("alloc_ready", a_ready, m_st[int'(a_wid)] == 0);
      chk("uop_commit_ready", uc_ready, m_crdy);
      chk("macro_valid", mc_valid, m_ov);
      if (m_ov) begin
        chk("macro_wid", mc_wid, m_owid);
        chk("macro_uuid", mc_uuid, m_ouuid);
      end
      eb = '0;
      for (int w = 0; w < NW; w++) eb[w] = (m_st[w] != 0);
      chk("busy_mask", busy, eb);
      chk("err_orphan", err, m_err);
      if (mc_valid && mc_ready && exp_q.size() > 0) begin
        logic [UW-1:0] e;
        e = exp_q.pop_front();
        chk("retire_order", mc_wid, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_alloc(input int w, input logic [UW-1:0] u, input int c);
    a_valid = 1'b1; a_wid = NWB'(w); a_uuid = u; a_cnt = CB'(c);
  endtask

  task automatic do_commit(input int w, input logic [UW-1:0] u);
    uc_valid = 1'b1; uc_wid = NWB'(w); uc_uuid = u;
  endtask

  task automatic idle_in();
    a_valid = 1'b0; uc_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    a_valid = 0; a_wid = 0; a_uuid = 0; a_cnt = 0;
    uc_valid = 0; uc_wid = 0; uc_uuid = 0; mc_ready = 1'b1;
    #1;
    chk("rst_valid", mc_valid, 0);
    chk("rst_wid", mc_wid, 0);
    chk("rst_uuid", mc_uuid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_uc_ready", uc_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step(); step();

    // Three-uop sequence on warp 1.
    do_alloc(1, 44'h10, 3); step(); idle_in();
    chk("t1_busy_active", busy[1], 1);
    do_commit(1, 44'h10); step(); step(); step(); idle_in();
    chk("t1_done_no_valid", mc_valid, 0);
    chk("t1_done_busy", busy[1], 1);
    step();
    chk("t1_valid", mc_valid, 1);
    chk("t1_wid", mc_wid, 1);
    chk("t1_uuid", mc_uuid, 44'h10);
    chk("t1_busy_clear", busy[1], 0);
    step();
    chk("t1_drained", mc_valid, 0);

    // Zero-length sequence on warp 2.
    do_alloc(2, 44'h22, 0); step(); idle_in();
    chk("t2_not_yet", mc_valid, 0);
    step();
    chk("t2_valid", mc_valid, 1);
    chk("t2_wid", mc_wid, 2);
    chk("t2_err", err, 0);
    step();

    // Orphan commits are dropped and flagged.
    do_alloc(1, 44'h20, 2); step(); idle_in();
    do_commit(3, 44'h5); step();
    chk("t3_err_idle", err, 1);
    do_commit(1, 44'h11); step();
    chk("t3_err_sticky", err, 1);
    do_commit(1, 44'h20); step(); idle_in(); step();
    chk("t3_still_busy", busy[1], 1);
    chk("t3_no_retire", mc_valid, 0);
    do_commit(1, 44'h20); step(); idle_in(); step();
    chk("t3_valid", mc_valid, 1);
    chk("t3_uuid", mc_uuid, 44'h20);
    step();

    // Round robin after last grant 3: order 0,1,2.
    do_alloc(3, 44'h33, 0); step(); idle_in(); step(); step();
    mc_ready = 1'b0;
    do_alloc(0, 44'h40, 0); step();
    do_alloc(1, 44'h41, 0); step();
    do_alloc(2, 44'h42, 0); step(); idle_in(); step();
    chk("t4_held_wid", mc_wid, 0);
    chk("t4_held_busy", busy, 4'b0110);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    mc_ready = 1'b1;
    step(); chk("t4_second", mc_wid, 1);
    step(); chk("t4_third", mc_wid, 2);
    step(); chk("t4_empty", mc_valid, 0);
    chk("t4_queue_drained", exp_q.size(), 0);

    // Round robin after last grant 1: order 2,0,1 behind the held warp 1.
    mc_ready = 1'b0;
    do_alloc(1, 44'h51, 0); step();
    do_alloc(0, 44'h50, 0); step();
    do_alloc(2, 44'h52, 0); step();
    do_alloc(1, 44'h53, 0); step(); idle_in();
    chk("t4b_held_wid", mc_wid, 1);
    chk("t4b_held_busy", busy, 4'b0111);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
    mc_ready = 1'b1;
    step(); chk("t4b_first", mc_wid, 2);
    step(); chk("t4b_second", mc_wid, 0);
    step(); chk("t4b_third", mc_wid, 1);
    chk("t4b_third_uuid", mc_uuid, 44'h53);
    step(); chk("t4b_empty", mc_valid, 0);
    chk("t4b_queue_drained", exp_q.size(), 0);

    // Alloc to a busy warp is refused.
    do_alloc(0, 44'h30, 1); step();
    do_alloc(0, 44'h31, 2); #1;
    chk("t5_busy_refused", a_ready, 0);
    step(); idle_in();
    do_commit(0, 44'h30); step(); idle_in();
    a_wid = 0; #1;
    chk("t5_done_refused", a_ready, 0);
    step();
    chk("t5_valid", mc_valid, 1);
    chk("t5_uuid", mc_uuid, 44'h30);
    chk("t5_ready_again", a_ready, 1);
    step();

    // Asynchronous reset mid-sequence with an output held.
    do_alloc(1, 44'h60, 3); step(); idle_in();
    do_commit(1, 44'h60); step(); idle_in();
    mc_ready = 1'b0;
    do_alloc(2, 44'h62, 0); step(); idle_in(); step();
    chk("t6_held", mc_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", mc_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_uuid", mc_uuid, 0);
    chk("t6_async_err", err, 0);
    chk("t6_async_ucrdy", uc_ready, 0);
    step(); step();
    rst = 1'b0;
    mc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_retire", mc_valid, 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      int w;
      a_valid  = ($urandom_range(0, 2) == 0);
      a_wid    = NWB'($urandom_range(0, NW - 1));
      a_uuid   = UW'($urandom_range(0, 3));
      a_cnt    = CB'($urandom_range(0, 8));
      w        = $urandom_range(0, NW - 1);
      uc_valid = ($urandom_range(0, 1) == 1);
      uc_wid   = NWB'(w);
      uc_uuid  = ($urandom_range(0, 3) != 0) ? m_uuid[w] : UW'($urandom_range(0, 3));
      mc_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_in();
    mc_ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
